// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control block: FSM state encoding,
// redirect source encoding, default kill depths and the redirect priority helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } pipe_state_e;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JAL    = 2'd2
  } redirect_src_e;

  localparam int DEF_FLUSH_DEPTH     = 2;
  localparam int DEF_JAL_FLUSH_DEPTH = 1;
  localparam int KILL_CNT_W          = 4;
  localparam logic [15:0] STAT_MAX   = 16'hFFFF;

  // A taken branch outranks a simultaneous JAL/JALR; the JAL is dropped.
  function automatic redirect_src_e redirect_src(input logic branch, input logic jal);
    redirect_src_e src;
    if (branch) begin
      src = SRC_BRANCH;
    end else if (jal) begin
      src = SRC_JAL;
    end else begin
      src = SRC_NONE;
    end
    return src;
  endfunction

endpackage

// File: rtl/pipe_kill_cnt.sv
// Loadable down-counter that tracks how many younger slots remain to be
// killed. Load wins over hold; the count never wraps below zero.
module pipe_kill_cnt
  import pipe_pkg::*;
#(
  parameter int W = KILL_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Counter register: load, hold, or decrement toward zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (hold) begin
      cnt_r <= cnt_r;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;
  assign zero  = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline redirect / stall controller. Turns branch and JAL redirects,
// jump-unit hazards and instruction-memory back-pressure into PC load,
// stall and kill controls. Optional statistics ports are built when the
// macro PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_DEPTH     = DEF_FLUSH_DEPTH,
  parameter int JAL_FLUSH_DEPTH = DEF_JAL_FLUSH_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        reset_branch,
  input  logic        reset_jal,
  input  logic [31:0] new_pc,
  input  logic        mem_busy,
  output logic        pc_load,
  output logic [31:0] redirect_pc,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        kill,
  output logic [1:0]  state
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [15:0] flush_count,
  output logic [15:0] stall_count
`endif
);

  localparam logic [KILL_CNT_W-1:0] BR_LOAD  = KILL_CNT_W'(FLUSH_DEPTH);
  localparam logic [KILL_CNT_W-1:0] JAL_LOAD = KILL_CNT_W'(JAL_FLUSH_DEPTH);
  localparam logic [KILL_CNT_W-1:0] CNT_ONE  = KILL_CNT_W'(1);
  localparam logic [KILL_CNT_W-1:0] CNT_ZERO = {KILL_CNT_W{1'b0}};

  pipe_state_e             state_r;
  pipe_state_e             base_state_s;
  pipe_state_e             nxt_state_s;
  redirect_src_e           pulse_src_s;
  redirect_src_e           load_src_s;
  redirect_src_e           pend_src_r;
  logic                    pend_r;
  logic [31:0]             pend_pc_r;
  logic [31:0]             redirect_pc_r;
  logic [31:0]             target_s;
  logic                    load_s;
  logic                    pend_set_s;
  logic                    pend_clr_s;
  logic [KILL_CNT_W-1:0]   load_val_s;
  logic [KILL_CNT_W-1:0]   cnt_s;
  logic                    cnt_zero_s;
  logic                    last_s;
  logic                    hold_s;
  logic                    kill_r;
  logic                    stall_fetch_r;
  logic                    stall_decode_r;

  pipe_kill_cnt #(.W(KILL_CNT_W)) u_kill_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .hold     (hold_s),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // The last kill slot is being consumed when one (or, defensively, zero) remains.
  assign last_s = cnt_zero_s || (cnt_s == CNT_ONE);
  // Kill slots only drain in FLUSH while memory can accept the next fetch.
  assign hold_s = (state_r != ST_FLUSH) || mem_busy;

  // Redirect arbitration and next-state decode; redirects win over halt and busy.
  always_comb begin
    pulse_src_s  = redirect_src(reset_branch, reset_jal);
    load_s       = 1'b0;
    load_src_s   = SRC_NONE;
    target_s     = redirect_pc_r;
    pend_set_s   = 1'b0;
    pend_clr_s   = 1'b0;
    base_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (pulse_src_s != SRC_NONE) begin
          load_s     = 1'b1;
          load_src_s = pulse_src_s;
          target_s   = new_pc;
        end else if (halt) begin
          base_state_s = ST_HALT;
        end else if (mem_busy) begin
          base_state_s = ST_WAIT;
        end else begin
          base_state_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (pulse_src_s != SRC_NONE) begin
          load_s     = 1'b1;
          load_src_s = pulse_src_s;
          target_s   = new_pc;
        end else if (halt) begin
          base_state_s = ST_HALT;
        end else begin
          base_state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (pulse_src_s != SRC_NONE) begin
          load_s     = 1'b1;
          load_src_s = pulse_src_s;
          target_s   = new_pc;
        end else if (mem_busy) begin
          base_state_s = ST_FLUSH;
        end else if (last_s) begin
          base_state_s = ST_RUN;
        end else begin
          base_state_s = ST_FLUSH;
        end
      end
      ST_WAIT: begin
        if (mem_busy) begin
          // Park the newest redirect until memory is ready again.
          pend_set_s   = (pulse_src_s != SRC_NONE);
          base_state_s = ST_WAIT;
        end else if (pulse_src_s != SRC_NONE) begin
          load_s     = 1'b1;
          load_src_s = pulse_src_s;
          target_s   = new_pc;
          pend_clr_s = 1'b1;
        end else if (pend_r) begin
          load_s     = 1'b1;
          load_src_s = pend_src_r;
          target_s   = pend_pc_r;
          pend_clr_s = 1'b1;
        end else begin
          base_state_s = ST_RUN;
        end
      end
      default: begin
        base_state_s = ST_RUN;
      end
    endcase
    load_val_s  = (load_src_s == SRC_BRANCH) ? BR_LOAD : JAL_LOAD;
    nxt_state_s = load_s ? ((load_val_s == CNT_ZERO) ? ST_RUN : ST_FLUSH) : base_state_s;
  end

  // FSM state register with registered stall/kill outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_RUN;
      kill_r         <= 1'b0;
      stall_fetch_r  <= 1'b0;
      stall_decode_r <= 1'b0;
    end else begin
      state_r        <= nxt_state_s;
      kill_r         <= (nxt_state_s != ST_RUN);
      stall_fetch_r  <= (nxt_state_s == ST_HALT) || (nxt_state_s == ST_WAIT);
      stall_decode_r <= (nxt_state_s == ST_HALT);
    end
  end

  // Pending redirect captured while memory is busy; newest pulse overwrites.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_r     <= 1'b0;
      pend_src_r <= SRC_NONE;
      pend_pc_r  <= 32'd0;
    end else if (pend_set_s) begin
      pend_r     <= 1'b1;
      pend_src_r <= pulse_src_s;
      pend_pc_r  <= new_pc;
    end else if (pend_clr_s) begin
      pend_r     <= 1'b0;
      pend_src_r <= SRC_NONE;
      pend_pc_r  <= pend_pc_r;
    end else begin
      pend_r     <= pend_r;
      pend_src_r <= pend_src_r;
      pend_pc_r  <= pend_pc_r;
    end
  end

  // Redirect target register, held until the next applied redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      redirect_pc_r <= 32'd0;
    end else if (load_s) begin
      redirect_pc_r <= target_s;
    end else begin
      redirect_pc_r <= redirect_pc_r;
    end
  end

  // pc_load is zero-latency but forced low while reset is held.
  assign pc_load      = load_s & reset;
  assign redirect_pc  = pc_load ? target_s : redirect_pc_r;
  assign stall_fetch  = stall_fetch_r;
  assign stall_decode = stall_decode_r;
  assign kill         = kill_r;
  assign state        = state_r;

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] flush_count_r;
  logic [15:0] stall_count_r;

  // Saturating count of applied redirects.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_count_r <= 16'd0;
    end else if (load_s && (flush_count_r != STAT_MAX)) begin
      flush_count_r <= flush_count_r + 16'd1;
    end else begin
      flush_count_r <= flush_count_r;
    end
  end

  // Saturating count of cycles spent in HALT or WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_r <= 16'd0;
    end else if (((state_r == ST_HALT) || (state_r == ST_WAIT)) && (stall_count_r != STAT_MAX)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign flush_count = flush_count_r;
  assign stall_count = stall_count_r;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, the number of younger pipeline slots killed on a taken branch.
REQ-002 SHALL have parameter JAL_FLUSH_DEPTH, default 1, the number of younger slots killed on a JAL/JALR redirect.
REQ-003 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port halt  in  1  jump-unit hazard stall request.
REQ-006 SHALL have port reset_branch  in  1  taken conditional branch, one-cycle pulse.
REQ-007 SHALL have port reset_jal  in  1  taken JAL/JALR, one-cycle pulse.
REQ-008 SHALL have port new_pc  in  32  redirect target.
REQ-009 SHALL have port mem_busy  in  1  instruction memory not ready.
REQ-010 SHALL have port pc_load  out  1  PC loads redirect_pc this cycle.
REQ-011 SHALL have port redirect_pc  out  32  registered redirect target.
REQ-012 SHALL have port stall_fetch  out  1  hold PC and the IF register.
REQ-013 SHALL have port stall_decode  out  1  hold the ID register.
REQ-014 SHALL have port kill  out  1  replace the issuing instruction with a bubble.
REQ-015 SHALL have port state  out  2  current FSM state, for debug.

Function
REQ-016 SHALL implement the FSM states RUN=0, HALT=1, FLUSH=2, WAIT=3.
REQ-017 In RUN, reset_branch SHALL latch new_pc, assert pc_load for one cycle, load the kill counter with FLUSH_DEPTH, and go to FLUSH on the next edge.
REQ-018 In RUN, reset_jal SHALL do the same as REQ-017 but load JAL_FLUSH_DEPTH.
REQ-019 If reset_branch and reset_jal assert in the same cycle, reset_branch SHALL win, FLUSH_DEPTH SHALL be used, and the JAL SHALL be discarded.
REQ-020 In FLUSH, kill SHALL be 1 and the counter SHALL decrement once per non-stalled cycle; the FSM SHALL return to RUN on the edge where the counter reaches 0.
REQ-021 In FLUSH, a new reset_branch SHALL reload the counter to FLUSH_DEPTH and latch the new target with pc_load=1 (the newest redirect wins).
REQ-022 In RUN, halt=1 with no redirect SHALL go to HALT, where stall_fetch=stall_decode=1 and kill=1 (bubble into EX); HALT SHALL return to RUN the first cycle halt=0.
REQ-023 In HALT, a redirect pulse SHALL take priority over halt: pc_load=1 and the FSM goes to FLUSH.
REQ-024 mem_busy=1 in RUN SHALL go to WAIT with stall_fetch=1 and kill=1; WAIT SHALL return to RUN when mem_busy=0.
REQ-025 A redirect arriving while in WAIT SHALL be held pending and applied (pc_load) on the first cycle mem_busy=0.
REQ-026 In FLUSH with mem_busy=1, the counter SHALL hold and kill SHALL remain 1.
REQ-027 pc_load SHALL be combinational from the redirect pulse, so it is zero-latency.
REQ-028 redirect_pc SHALL be registered, valid from the same cycle via bypass, and held until the next redirect.
REQ-029 A FLUSH_DEPTH of 0 SHALL go directly back to RUN with no kill cycles.

Reset
REQ-030 On reset low, the block SHALL immediately enter RUN with the counter=0, redirect_pc=0, the pending flag=0, and pc_load=stall_fetch=stall_decode=kill=0.
REQ-031 Reset asserted mid-FLUSH or mid-HALT SHALL abort the operation; after release the block SHALL sit in RUN with no redirect replayed.

Configuration
REQ-032 With PIPE_CTRL_STATS_EN defined, the block SHALL add outputs flush_count[15:0] and stall_count[15:0]: saturating counters of redirects and of HALT/WAIT cycles, cleared by reset.
REQ-033 Without PIPE_CTRL_STATS_EN, those ports and counters SHALL be absent and the rest of the behaviour SHALL be identical.

Structure
REQ-034 A shared package pipe_pkg SHALL hold the state encoding (RUN/HALT/FLUSH/WAIT), the redirect source enum (NONE/BRANCH/JAL), and the default depth constants.
REQ-035 Sub-module pipe_kill_cnt (a loadable down-counter with hold and zero flag) SHALL be instantiated once.

Verification
REQ-036 Bench SHALL apply reset_branch with new_pc=0x100 in RUN -> pc_load=1 same cycle, kill=1 for exactly 2 cycles, then RUN.
REQ-037 Bench SHALL apply reset_jal with new_pc=0x40 -> kill=1 for 1 cycle, redirect_pc=0x40.
REQ-038 Bench SHALL pulse reset_branch (0x200) and reset_jal (0x300) together -> redirect_pc=0x200, 2 kill cycles.
REQ-039 Bench SHALL hold halt=1 for 3 cycles -> state=HALT, stall_fetch=stall_decode=1 for 3 cycles, then RUN.
REQ-040 Bench SHALL set mem_busy=1 for 4 cycles with reset_branch (0x80) in cycle 2 -> pc_load in cycle 5 and redirect_pc=0x80.
REQ-041 Bench SHALL drop reset low during the second FLUSH cycle -> all outputs 0 immediately and state=RUN after release.
